// File: rtl/fifo_to_uart_pkg.sv
// Shared definitions for the transceiver-to-UART byte bridge.
//   SOF / LANE_MARK : lane marker values recognised on the receive stream
//   HDR_BYTES       : number of header bytes stored and counted toward len
//   BUSY_CYCLES     : cycles after reset release before the FIFO accepts traffic
//   frame_state_t   : frame FSM states
//   popcount4       : number of set bits in a 4-bit lane mask
package fifo_to_uart_pkg;

    localparam logic [7:0]  SOF         = 8'h7E;
    localparam logic [7:0]  LANE_MARK   = 8'h5D;
    localparam int          HDR_BYTES   = 4;
    localparam logic [15:0] HDR_LEN     = 16'(HDR_BYTES);
    localparam int          BUSY_CYCLES = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } frame_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/byte_fifo_mw.sv
// Byte FIFO with up to four writes and one read per clock.
//   clk, srst : clock and synchronous active-high reset
//   wr_mask   : byte-valid mask, bit 3 = first byte (wr_data[31:24])
//   wr_data   : four candidate bytes, MSB lane first
//   rd_en     : pop one byte (ignored when empty)
//   rd_data   : registered popped byte, holds when no pop occurs
//   count     : bytes currently stored (0..DEPTH)
// Masked bytes land in consecutive slots in mask order; bytes that do not
// fit in the free space (counting the slot freed by a same-cycle read) are
// dropped, so the write pointer never overtakes the read pointer.
module byte_fifo_mw
    import fifo_to_uart_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [3:0]       wr_mask,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       rd_data_reg;

    logic             rd_ok;
    logic [CNT_W-1:0] free_space;
    logic [3:0][2:0]  slot_off;
    logic [3:0]       slot_we;
    logic [2:0]       off_acc;
    logic [2:0]       n_wr;

    assign rd_ok      = rd_en && (count_reg != '0);
    assign free_space = CNT_W'(DEPTH) - count_reg + CNT_W'(rd_ok);

    // Each masked byte's slot offset is the number of masked bytes ahead of it.
    always_comb begin
        off_acc  = '0;
        slot_off = '0;
        slot_we  = '0;
        for (int i = 3; i >= 0; i--) begin
            slot_off[i] = off_acc;
            slot_we[i]  = wr_mask[i] && (CNT_W'(off_acc) < free_space);
            off_acc     = off_acc + 3'(wr_mask[i]);
        end
    end

    assign n_wr = popcount4(slot_we);

    // Memory array: no reset so it maps onto RAM; the read at a full FIFO
    // returns the old contents of a slot that is overwritten on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (slot_we[i]) begin
                mem[wr_ptr_reg + AW'(slot_off[i])] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(n_wr);
            count_reg  <= count_reg + CNT_W'(n_wr) - CNT_W'(rd_ok);
            if (rd_ok) begin
                rd_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/fifo_to_uart_bridge.sv
// Bridges a 64-bit transceiver receive stream to a byte FIFO read by a UART.
//   i_clk, i_rst     : clock and synchronous active-high reset
//   i_resetdone      : transceiver ready; all rx input ignored when low
//   i_rx_data        : four lanes {marker, byte}, L3 = [63:48] .. L0 = [15:0]
//   i_rxcharisk      : K-char flags, bits [2k+1:2k] belong to lane k
//   i_fifo_rd_en     : pop one byte
//   o_fifo_data_out  : popped byte (one-cycle latency, holds otherwise)
//   o_rd_data_count  : bytes stored
//   o_wr_rst_busy,
//   o_rd_rst_busy    : FIFO not yet ready after reset
// A 7E header word stores its four header bytes and loads the remaining
// payload length; following words contribute their valid lanes, MSB first,
// until the length is exhausted or a K-character word aborts the frame.
module fifo_to_uart_bridge #(
    parameter int DEPTH = 512,
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_resetdone,
    input  logic [63:0]      i_rx_data,
    input  logic [7:0]       i_rxcharisk,
    input  logic             i_fifo_rd_en,
    output logic [7:0]       o_fifo_data_out,
    output logic [CNT_W-1:0] o_rd_data_count,
    output logic             o_wr_rst_busy,
    output logic             o_rd_rst_busy
);

    import fifo_to_uart_pkg::*;

    logic         busy_reg;
    logic [2:0]   busy_cnt_reg;
    frame_state_t state_reg;
    logic [15:0]  remaining_reg;

    logic [3:0]   lane_valid;
    logic [31:0]  lane_bytes;
    logic         rx_active;
    logic         is_header;
    logic [15:0]  hdr_len;
    logic [3:0]   pay_mask;
    logic [31:0]  pay_data;
    logic [2:0]   take_cnt;
    logic [1:0]   slot_idx;
    logic [15:0]  rem_next;
    logic [3:0]   fifo_wr_mask;
    logic [31:0]  fifo_wr_data;

    // Lane qualifier: only L3 may carry the SOF marker as a data lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] marker;
        assign marker               = i_rx_data[16*gi+8 +: 8];
        assign lane_bytes[8*gi +: 8] = i_rx_data[16*gi +: 8];
        assign lane_valid[gi] = i_resetdone
                             && (i_rxcharisk[2*gi +: 2] == 2'b00)
                             && ((marker == LANE_MARK) || ((gi == 3) && (marker == SOF)));
    end

    assign rx_active = i_resetdone && !busy_reg;
    assign is_header = rx_active && (i_rxcharisk == 8'h00) && (i_rx_data[63:56] == SOF);
    assign hdr_len   = {i_rx_data[39:32], i_rx_data[23:16]};

    // Compaction: keep the first `remaining` valid lanes, packed MSB first.
    always_comb begin
        pay_mask = '0;
        pay_data = '0;
        take_cnt = '0;
        slot_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (lane_valid[i] && (16'(take_cnt) < remaining_reg)) begin
                slot_idx                  = 2'd3 - take_cnt[1:0];
                pay_mask[slot_idx]        = 1'b1;
                pay_data[8*slot_idx +: 8] = lane_bytes[8*i +: 8];
                take_cnt                  = take_cnt + 3'd1;
            end
        end
    end

    assign rem_next = remaining_reg - 16'(take_cnt);

    always_comb begin
        fifo_wr_mask = '0;
        fifo_wr_data = '0;
        if (is_header) begin
            fifo_wr_mask = 4'hF;
            fifo_wr_data = {i_rx_data[55:48], i_rx_data[39:32], i_rx_data[23:16], i_rx_data[7:0]};
        end else if (rx_active && (state_reg == PAYLOAD) && (i_rxcharisk == 8'h00)) begin
            fifo_wr_mask = pay_mask;
            fifo_wr_data = pay_data;
        end
    end

    // Frame FSM. remaining_reg is kept at 0 whenever the FSM is IDLE so the
    // compaction logic never selects lanes outside a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
        end else if (!rx_active || (i_rxcharisk != 8'h00)) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
        end else if (is_header) begin
            if (hdr_len > HDR_LEN) begin
                state_reg     <= PAYLOAD;
                remaining_reg <= hdr_len - HDR_LEN;
            end else begin
                state_reg     <= IDLE;
                remaining_reg <= '0;
            end
        end else if (state_reg == PAYLOAD) begin
            remaining_reg <= rem_next;
            if (rem_next == 16'd0) begin
                state_reg <= IDLE;
            end
        end
    end

    // Busy flags stay up for BUSY_CYCLES edges after reset is released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_reg     <= 1'b1;
            busy_cnt_reg <= '0;
        end else if (busy_reg) begin
            busy_cnt_reg <= busy_cnt_reg + 3'd1;
            if (busy_cnt_reg == 3'(BUSY_CYCLES - 1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    byte_fifo_mw #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (i_clk),
        .srst    (i_rst),
        .wr_mask (fifo_wr_mask),
        .wr_data (fifo_wr_data),
        .rd_en   (i_fifo_rd_en && !busy_reg),
        .rd_data (o_fifo_data_out),
        .count   (o_rd_data_count)
    );

    assign o_wr_rst_busy = busy_reg;
    assign o_rd_rst_busy = busy_reg;

endmodule

// File: tb/tb_fifo_to_uart_bridge.sv
// Self-checking bench for fifo_to_uart_bridge. A queue-based reference model
// derives the expected FIFO contents word by word from the framing rules.
module tb_fifo_to_uart_bridge;

    localparam int DEPTH = 512;
    localparam int CNT_W = 10;
    localparam logic [63:0] IDLE_W = 64'h0;

    logic             clk = 1'b0;
    logic             rst;
    logic             resetdone;
    logic [63:0]      rx_data;
    logic [7:0]       rxcharisk;
    logic             rd_en;
    logic [7:0]       data_out;
    logic [CNT_W-1:0] rd_count;
    logic             wr_busy;
    logic             rd_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    bit         m_in_frame;
    int         m_rem;

    always #5 clk = ~clk;

    fifo_to_uart_bridge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_resetdone     (resetdone),
        .i_rx_data       (rx_data),
        .i_rxcharisk     (rxcharisk),
        .i_fifo_rd_en    (rd_en),
        .o_fifo_data_out (data_out),
        .o_rd_data_count (rd_count),
        .o_wr_rst_busy   (wr_busy),
        .o_rd_rst_busy   (rd_busy)
    );

    function automatic logic [63:0] hdr_word(input logic [7:0] typ, input logic [15:0] len);
        return {8'h7E, typ, 8'h5D, len[15:8], 8'h5D, len[7:0], 8'h5D, 8'h00};
    endfunction

    function automatic logic [63:0] pay_word(input logic [7:0] b3, input logic [7:0] b2,
                                             input logic [7:0] b1, input logic [7:0] b0);
        return {8'h5D, b3, 8'h5D, b2, 8'h5D, b1, 8'h5D, b0};
    endfunction

    // Model of one input word: pop first (if anything is stored), then store
    // the bytes the framing rules produce until the FIFO is full.
    task automatic model_word(input logic [63:0] d, input logic [7:0] k,
                              input logic rdone, input logic rdn);
        logic [7:0] nb[$];
        logic [7:0] mk;
        int         len;
        if (rdn && m_q.size() > 0) m_last = m_q.pop_front();
        if (!rdone || k != 8'h00) begin
            m_in_frame = 0;
        end else if (d[63:56] == 8'h7E) begin
            nb.push_back(d[55:48]);
            nb.push_back(d[39:32]);
            nb.push_back(d[23:16]);
            nb.push_back(d[7:0]);
            len        = int'({d[39:32], d[23:16]});
            m_rem      = (len > 4) ? len - 4 : 0;
            m_in_frame = (m_rem > 0);
        end else if (m_in_frame) begin
            for (int l = 3; l >= 0; l--) begin
                mk = d[16*l+8 +: 8];
                if (m_rem > 0 && (mk == 8'h5D || (l == 3 && mk == 8'h7E))) begin
                    nb.push_back(d[16*l +: 8]);
                    m_rem--;
                end
            end
            m_in_frame = (m_rem > 0);
        end
        foreach (nb[i]) if (m_q.size() < DEPTH) m_q.push_back(nb[i]);
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] k,
                        input logic rdn, input logic rdone);
        rx_data   = d;
        rxcharisk = k;
        rd_en     = rdn;
        resetdone = rdone;
        model_word(d, k, rdone, rdn);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; resetdone = 1'b1; rx_data = '0; rxcharisk = 8'hFF; rd_en = 1'b0;
        m_q.delete(); m_last = 8'h00; m_in_frame = 0; m_rem = 0;
        repeat (10) begin @(posedge clk); #1; end
        tests_run++;
        if (rd_count !== '0 || data_out !== 8'h00 || wr_busy !== 1'b1 || rd_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d data=%h busy=%b%b, required 0 00 11",
                     rd_count, data_out, wr_busy, rd_busy);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (wr_busy !== (i < 4) || rd_busy !== (i < 4)) begin
                tests_failed++;
                $display("FAIL busy_release cycle %0d: busy=%b%b, required %0b", i, wr_busy, rd_busy, i < 4);
            end
        end
        $display("[TB] reset done");
    endtask

    task automatic test_frame29();
        logic [7:0] exp[$];
        exp = '{8'h01, 8'h00, 8'h1D, 8'h00};
        for (int n = 0; n < 6; n++) repeat (4) exp.push_back(8'(n));
        exp.push_back(8'hFF);
        step(hdr_word(8'h01, 16'd29), 8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) step(pay_word(8'(n), 8'(n), 8'(n), 8'(n)), 8'h00, 1'b0, 1'b1);
        step(64'h5DFF_0000_0000_0000, 8'h00, 1'b0, 1'b1);
        step(IDLE_W, 8'hFF, 1'b0, 1'b1);
        $display("[TB] frame len=29 type=01 sent");
        tests_run++;
        if (rd_count !== 10'd29) begin
            tests_failed++;
            $display("FAIL frame29_count: got %0d, required 29", rd_count);
        end
        for (int i = 0; i < 29; i++) begin
            step(IDLE_W, 8'hFF, 1'b1, 1'b1);
            tests_run++;
            if (data_out !== exp[i]) begin
                tests_failed++;
                $display("FAIL frame29_read[%0d]: got %h, required %h", i, data_out, exp[i]);
            end
        end
        tests_run++;
        if (rd_count !== '0) begin
            tests_failed++;
            $display("FAIL frame29_drained: got %0d, required 0", rd_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] last;
        for (int f = 0; f < 3; f++) begin
            step(hdr_word(8'(f + 1), 16'(29 + f)), 8'h00, 1'b0, 1'b1);
            for (int w = 0; w < (29 + f - 4 + 3) / 4; w++)
                step(pay_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 8'h00, 1'b0, 1'b1);
            step(IDLE_W, 8'hFF, 1'b0, 1'b1);
            $display("[TB] back-to-back frame len=%0d type=%0d sent", 29 + f, f + 1);
        end
        tests_run++;
        if (rd_count !== 10'd90) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d, required 90", rd_count);
        end
        for (int i = 0; i < 90; i++) begin
            step(IDLE_W, 8'hFF, 1'b1, 1'b1);
            tests_run++;
            if (data_out !== m_last) begin
                tests_failed++;
                $display("FAIL b2b_read[%0d]: got %h, required %h", i, data_out, m_last);
            end
        end
        last = m_last;
        step(IDLE_W, 8'hFF, 1'b1, 1'b1);
        tests_run++;
        if (data_out !== last || rd_count !== '0) begin
            tests_failed++;
            $display("FAIL b2b_read_empty: got data %h count %0d, required %h 0", data_out, rd_count, last);
        end
    endtask

    task automatic test_abort();
        step(hdr_word(8'h0A, 16'd40), 8'h00, 1'b0, 1'b1);
        repeat (2) step(pay_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 8'h00, 1'b0, 1'b1);
        step(pay_word(8'h11, 8'h22, 8'h33, 8'h44), 8'hFF, 1'b0, 1'b1);
        repeat (3) step(pay_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 8'h00, 1'b0, 1'b1);
        $display("[TB] aborted frame sent");
        tests_run++;
        if (rd_count !== 10'd12) begin
            tests_failed++;
            $display("FAIL abort_count: got %0d, required 12", rd_count);
        end
        for (int i = 0; i < 12; i++) begin
            step(IDLE_W, 8'hFF, 1'b1, 1'b1);
            tests_run++;
            if (data_out !== m_last) begin
                tests_failed++;
                $display("FAIL abort_read[%0d]: got %h, required %h", i, data_out, m_last);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [7:0]  k;
        int          sel;
        int          errs = 0;
        for (int c = 0; c < 400; c++) begin
            sel = int'($urandom_range(0, 99));
            k   = 8'h00;
            if (sel < 10) begin
                d = hdr_word(8'($urandom), 16'($urandom_range(0, 24)));
            end else if (sel < 18) begin
                d = 64'($urandom);
                k = 8'($urandom_range(1, 255));
            end else begin
                d = pay_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                for (int l = 0; l < 4; l++) begin
                    sel = int'($urandom_range(0, 7));
                    if (sel == 0) d[16*l+8 +: 8] = 8'h7E;
                    else if (sel == 1) d[16*l+8 +: 8] = 8'($urandom);
                end
                if ($urandom_range(0, 9) == 0) k = 8'(1 << $urandom_range(0, 7));
            end
            step(d, k, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
            tests_run++;
            if (rd_count !== CNT_W'(m_q.size()) || data_out !== m_last) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("FAIL random[%0d]: count %0d data %h, required %0d %h",
                             c, rd_count, data_out, m_q.size(), m_last);
            end
        end
        while (m_q.size() > 0) step(IDLE_W, 8'hFF, 1'b1, 1'b1);
        tests_run++;
        if (rd_count !== '0 || data_out !== m_last) begin
            tests_failed++;
            $display("FAIL random_drain: count %0d data %h, required 0 %h", rd_count, data_out, m_last);
        end
        $display("[TB] random traffic done");
    endtask

    task automatic test_full();
        step(hdr_word(8'h5A, 16'd600), 8'h00, 1'b0, 1'b1);
        repeat (126) step(pay_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 8'h00, 1'b0, 1'b1);
        step({8'h5D, 8'($urandom), 8'h5D, 8'($urandom), 8'h00, 8'hEE, 8'h00, 8'hEE}, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (rd_count !== 10'(DEPTH - 2)) begin
            tests_failed++;
            $display("FAIL full_prefill: got %0d, required %0d", rd_count, DEPTH - 2);
        end
        step(pay_word(8'hA1, 8'hA2, 8'hA3, 8'hA4), 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (rd_count !== 10'(DEPTH) || m_q[DEPTH-1] !== 8'hA2) begin
            tests_failed++;
            $display("FAIL full_overflow: got %0d, required %0d", rd_count, DEPTH);
        end
        step(pay_word(8'hB1, 8'hB2, 8'hB3, 8'hB4), 8'h00, 1'b1, 1'b1);
        tests_run++;
        if (rd_count !== 10'(DEPTH) || data_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL full_rdwr: count %0d data %h, required %0d 5a", rd_count, data_out, DEPTH);
        end
        $display("[TB] full FIFO scenario sent");
        for (int i = 0; i < DEPTH; i++) begin
            step(IDLE_W, 8'hFF, 1'b1, 1'b1);
            tests_run++;
            if (data_out !== m_last) begin
                tests_failed++;
                $display("FAIL full_read[%0d]: got %h, required %h", i, data_out, m_last);
            end
        end
        step(hdr_word(8'h33, 16'd2), 8'h00, 1'b1, 1'b1);
        tests_run++;
        if (rd_count !== 10'd4 || data_out !== m_last) begin
            tests_failed++;
            $display("FAIL empty_rdwr: count %0d data %h, required 4 %h", rd_count, data_out, m_last);
        end
        repeat (4) step(IDLE_W, 8'hFF, 1'b1, 1'b1);
        tests_run++;
        if (data_out !== 8'h00 || rd_count !== '0) begin
            tests_failed++;
            $display("FAIL short_header: data %h count %0d, required 00 0", data_out, rd_count);
        end
    endtask

    task automatic test_resetdone();
        step(hdr_word(8'h01, 16'd12), 8'h00, 1'b0, 1'b0);
        repeat (2) step(pay_word(8'h10, 8'h20, 8'h30, 8'h40), 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (rd_count !== '0) begin
            tests_failed++;
            $display("FAIL resetdone_low: got %0d, required 0", rd_count);
        end
        step(pay_word(8'h10, 8'h20, 8'h30, 8'h40), 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (rd_count !== '0) begin
            tests_failed++;
            $display("FAIL idle_discard: got %0d, required 0", rd_count);
        end
        $display("[TB] resetdone-low frame sent");
    endtask

    initial begin
        test_reset();
        test_frame29();
        test_back_to_back();
        test_abort();
        test_random();
        test_full();
        test_resetdone();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
